// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the single-outstanding Wishbone command master:
// FSM state encoding, response flag bundle and the response-data rule.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RSP
  } state_t;

  typedef struct packed {
    logic err;
    logic timeout;
  } rsp_flags_t;

  // Read data is only returned on a clean read ack; writes and errors report zero.
  function automatic logic [31:0] resp_data(input logic err, input logic we,
                                            input logic [31:0] rdata);
    return (err || we) ? 32'h0 : rdata;
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone B4 pipelined bus signals of wb_cmd_master.
// master = the command master itself, slave = whatever sits around it.
interface wb_cmd_master_if #(
  parameter int AW = 8
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [31:0]   cmd_data_i;
  logic [3:0]    cmd_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_data_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_data_o;
  logic [3:0]    wb_sel_o;
  logic          wb_stall_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [31:0]   wb_data_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_data_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_data_i
  );

endinterface

// File: rtl/wb_cmd_master.sv
// Turns one command at a time into a Wishbone B4 pipelined single access and
// returns the result (data / error / timeout) through a valid-ready response.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_cmd_master_if.master  bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  state_t        state_reg, state_next;
  logic          cyc_reg, cyc_next;
  logic          stb_reg, stb_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   data_reg, data_next;
  logic [3:0]    sel_reg, sel_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [31:0]   rsp_data_reg, rsp_data_next;
  rsp_flags_t    rsp_flags_reg, rsp_flags_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          bus_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      sel_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_flags_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      sel_reg       <= sel_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_flags_reg <= rsp_flags_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    sel_next       = sel_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_flags_next = rsp_flags_reg;
    cnt_next       = cnt_reg;
    cnt_inc        = cnt_reg + 1'b1;
    bus_done       = bus.wb_ack_i || bus.wb_err_i;

    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          we_next    = bus.cmd_we_i;
          addr_next  = bus.cmd_addr_i;
          data_next  = bus.cmd_data_i;
          sel_next   = bus.cmd_sel_i;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          cnt_next   = '0;
          state_next = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_next = cnt_inc;
        // A termination on the very cycle the limit is reached beats the timeout.
        if (bus_done) begin
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_flags_next = '{err: bus.wb_err_i, timeout: 1'b0};
          rsp_data_next  = resp_data(bus.wb_err_i, we_reg, bus.wb_data_i);
          state_next     = ST_RSP;
        end else if (cnt_inc == TO_LIMIT) begin
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_flags_next = '{err: 1'b1, timeout: 1'b1};
          rsp_data_next  = '0;
          state_next     = ST_RSP;
        end else if (state_reg == ST_REQ && !bus.wb_stall_i) begin
          stb_next   = 1'b0;
          state_next = ST_WAIT;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gated with rst_i so ready is low while reset is held and high right after.
  assign bus.cmd_ready_o   = (state_reg == ST_IDLE) && !rst_i;
  assign bus.rsp_valid_o   = rsp_valid_reg;
  assign bus.rsp_data_o    = rsp_data_reg;
  assign bus.rsp_err_o     = rsp_flags_reg.err;
  assign bus.rsp_timeout_o = rsp_flags_reg.timeout;
  assign bus.wb_cyc_o      = cyc_reg;
  assign bus.wb_stb_o      = stb_reg;
  assign bus.wb_we_o       = we_reg;
  assign bus.wb_addr_o     = addr_reg;
  assign bus.wb_data_o     = data_reg;
  assign bus.wb_sel_o      = sel_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a configurable Wishbone slave, a response
// monitor popping expected results, and directed plus randomised commands.
module tb_wb_cmd_master;

  localparam int AW = 8;
  localparam int T  = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  wb_cmd_master_if #(.AW(AW)) bus ();

  wb_cmd_master #(.AW(AW), .TIMEOUT(T)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    sel;
    logic [31:0]   data;
    logic          err;
    logic          to;
    int            lat;
    int            stb;
    int            acc;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle_n = 0;

  // slave behaviour: mode 0 acks in the accepting stb cycle, 1 one cycle later, 2 never
  int          cfg_stall = 0;
  int          cfg_mode  = 0;
  logic        cfg_ack   = 1'b1;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          cfg_hold  = 0;
  logic        extra_ack = 1'b0;
  int          hs_cycle  = -10;

  always @(posedge clk_i) cycle_n <= cycle_n + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wishbone slave model
  int stall_left = 0;
  bit pending    = 0;
  always @(negedge clk_i) begin
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_data_i  = 32'h0;
    if (rst_i || !bus.wb_cyc_o) begin
      stall_left = cfg_stall;
      pending    = 0;
    end else if (bus.wb_stb_o) begin
      if (stall_left > 0) begin
        bus.wb_stall_i = 1'b1;
        stall_left--;
      end else if (cfg_mode == 0) begin
        bus.wb_ack_i  = cfg_ack;
        bus.wb_err_i  = cfg_err;
        bus.wb_data_i = cfg_rdata;
      end else if (cfg_mode == 1) begin
        pending = 1;
      end
    end else if (pending) begin
      bus.wb_ack_i  = cfg_ack;
      bus.wb_err_i  = cfg_err;
      bus.wb_data_i = cfg_rdata;
      pending       = 0;
    end
    if (extra_ack) bus.wb_ack_i = 1'b1;
  end

  // Response monitor / scoreboard consumer, also drives rsp_ready_i
  exp_t cur;
  bit   in_rsp    = 0;
  int   stb_seen  = 0;
  int   hold_left = 0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      in_rsp          = 0;
      stb_seen        = 0;
      bus.rsp_ready_i = 1'b0;
    end else begin
      if (bus.wb_stb_o) begin
        stb_seen++;
        if (q.size() > 0) begin
          check_eq("wb_we",   64'(bus.wb_we_o),   64'(q[0].we));
          check_eq("wb_addr", 64'(bus.wb_addr_o), 64'(q[0].addr));
          check_eq("wb_data", 64'(bus.wb_data_o), 64'(q[0].wdata));
          check_eq("wb_sel",  64'(bus.wb_sel_o),  64'(q[0].sel));
        end
      end
      if (bus.rsp_valid_o) begin
        if (!in_rsp) begin
          if (q.size() == 0) begin
            check_eq("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            cur       = q.pop_front();
            in_rsp    = 1;
            hold_left = cfg_hold;
            check_eq("latency",   64'(cycle_n - cur.acc), 64'(cur.lat));
            check_eq("stb_count", 64'(stb_seen), 64'(cur.stb));
            check_eq("cyc_drop",  64'(bus.wb_cyc_o), 64'd0);
            check_eq("stb_drop",  64'(bus.wb_stb_o), 64'd0);
            stb_seen = 0;
          end
        end
        if (in_rsp) begin
          check_eq("rsp_data",    64'(bus.rsp_data_o),    64'(cur.data));
          check_eq("rsp_err",     64'(bus.rsp_err_o),     64'(cur.err));
          check_eq("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(cur.to));
          if (hold_left > 0) begin
            bus.rsp_ready_i = 1'b0;
            hold_left--;
            check_eq("cmd_ready_hold", 64'(bus.cmd_ready_o), 64'd0);
          end else begin
            bus.rsp_ready_i = 1'b1;
            hs_cycle        = cycle_n;
            in_rsp          = 0;
          end
        end else begin
          bus.rsp_ready_i = 1'b1;
        end
      end else begin
        bus.rsp_ready_i = 1'b0;
      end
      if (!bus.wb_cyc_o && !bus.rsp_valid_o) stb_seen = 0;
    end
  end

  task automatic set_slave(input int stall, input int mode, input logic ack,
                           input logic err, input logic [31:0] rdata);
    cfg_stall = stall;
    cfg_mode  = mode;
    cfg_ack   = ack;
    cfg_err   = err;
    cfg_rdata = rdata;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input bit push, input bit b2b);
    exp_t e;
    bit   ok = 0;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = wdata;
    bus.cmd_sel_i   = sel;
    bus.cmd_valid_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.cmd_ready_o) begin
        ok = 1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) begin
      check_eq("cmd_accept", 64'd0, 64'd1);
    end else begin
      if (b2b) check_eq("b2b_accept_cycle", 64'(cycle_n), 64'(hs_cycle + 1));
      if (push) begin
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.sel   = sel;
        if (cfg_mode == 2) begin
          e.data = 32'h0;
          e.err  = 1'b1;
          e.to   = 1'b1;
          e.lat  = T + 1;
          e.stb  = (cfg_stall + 1 < T) ? cfg_stall + 1 : T;
        end else begin
          e.err  = cfg_err;
          e.to   = 1'b0;
          e.data = (cfg_err || we) ? 32'h0 : cfg_rdata;
          e.lat  = cfg_stall + 2 + ((cfg_mode == 1) ? 1 : 0);
          e.stb  = cfg_stall + 1;
        end
        e.acc = cycle_n;
        q.push_back(e);
      end
    end
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (q.size() == 0 && !bus.rsp_valid_o && bus.cmd_ready_o) begin
        done = 1;
        break;
      end
    end
    if (!done) check_eq("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.cmd_sel_i   = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("rst_cyc",       64'(bus.wb_cyc_o),      64'd0);
    check_eq("rst_stb",       64'(bus.wb_stb_o),      64'd0);
    check_eq("rst_we",        64'(bus.wb_we_o),       64'd0);
    check_eq("rst_addr",      64'(bus.wb_addr_o),     64'd0);
    check_eq("rst_wdata",     64'(bus.wb_data_o),     64'd0);
    check_eq("rst_sel",       64'(bus.wb_sel_o),      64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid_o),   64'd0);
    check_eq("rst_rsp_data",  64'(bus.rsp_data_o),    64'd0);
    check_eq("rst_rsp_err",   64'(bus.rsp_err_o),     64'd0);
    check_eq("rst_rsp_to",    64'(bus.rsp_timeout_o), 64'd0);
    check_eq("rst_cmd_ready", 64'(bus.cmd_ready_o),   64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("ready_after_rst", 64'(bus.cmd_ready_o), 64'd1);

    // read, registered ack
    set_slave(0, 1, 1'b1, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 8'h10, 32'h0, 4'hF, 1, 0);
    wait_done();
    // read, ack in the stb cycle
    set_slave(0, 0, 1'b1, 1'b0, 32'hA5A50F0F);
    issue(1'b0, 8'h11, 32'h0, 4'h3, 1, 0);
    wait_done();
    // write with 3 stall cycles; ack lands on the cycle the counter hits TIMEOUT
    set_slave(3, 0, 1'b1, 1'b0, 32'hFFFF0000);
    issue(1'b1, 8'h04, 32'h12345678, 4'hF, 1, 0);
    wait_done();
    // ack and err together
    set_slave(0, 0, 1'b1, 1'b1, 32'hCAFEF00D);
    issue(1'b0, 8'h22, 32'h0, 4'hF, 1, 0);
    wait_done();
    // err only, registered
    set_slave(0, 1, 1'b0, 1'b1, 32'h13572468);
    issue(1'b0, 8'h23, 32'h0, 4'hF, 1, 0);
    wait_done();
    // silent slave, timeout from WAIT and from a permanently stalled REQ
    set_slave(0, 2, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 8'h30, 32'h0, 4'hF, 1, 0);
    wait_done();
    set_slave(10, 2, 1'b0, 1'b0, 32'h0);
    issue(1'b1, 8'h31, 32'h55AA55AA, 4'h5, 1, 0);
    wait_done();

    // response held 5 cycles, stray ack during RSP, then back-to-back command
    set_slave(0, 0, 1'b1, 1'b0, 32'h1234ABCD);
    cfg_hold = 5;
    issue(1'b0, 8'h40, 32'h0, 4'hF, 1, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    extra_ack = 1'b1;
    @(negedge clk_i);
    extra_ack = 1'b0;
    cfg_hold  = 0;
    issue(1'b0, 8'h41, 32'h0, 4'hF, 1, 1);
    wait_done();

    // randomised mix within the timeout window
    for (int n = 0; n < 6; n++) begin
      set_slave($urandom_range(0, 2), $urandom_range(0, 1), 1'b1, 1'b0, $urandom);
      issue(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom), 1, 0);
      wait_done();
    end

    // reset while in WAIT, then a late ack in IDLE
    set_slave(0, 2, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 8'h50, 32'h0, 4'hF, 0, 0);
    @(negedge clk_i);
    check_eq("cyc_before_rst", 64'(bus.wb_cyc_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rstw_cyc",       64'(bus.wb_cyc_o),    64'd0);
    check_eq("rstw_stb",       64'(bus.wb_stb_o),    64'd0);
    check_eq("rstw_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    extra_ack = 1'b1;
    @(negedge clk_i);
    extra_ack = 1'b0;
    check_eq("rstw_ready", 64'(bus.cmd_ready_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_eq("late_ack_ignored", 64'(bus.rsp_valid_o), 64'd0);
    end

    // recovery read
    set_slave(0, 0, 1'b1, 1'b0, 32'h0BADF00D);
    issue(1'b0, 8'h60, 32'h0, 4'hF, 1, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter AW, default 8: Wishbone word-address width.
REQ-002 Parameter TIMEOUT, default 255: maximum bus cycles per transaction before abort; legal range 1..65535.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; transfer when both high.
REQ-007 cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i  in  1, AW, 32, 4  command write flag, word address, write data, byte enables.
REQ-008 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake; transfer when both high.
REQ-009 rsp_data_o, rsp_err_o, rsp_timeout_o  out  32, 1, 1  read data, error flag, timeout flag.
REQ-010 wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o  out  1, 1, 1, AW, 32, 4  Wishbone B4 pipelined master outputs.
REQ-011 wb_stall_i, wb_ack_i, wb_err_i, wb_data_i  in  1, 1, 1, 32  Wishbone slave responses.

Function
REQ-012 FSM states: IDLE, REQ, WAIT, RSP; all Wishbone and response outputs SHALL be registered.
REQ-013 cmd_ready_o SHALL be high only in IDLE.
REQ-014 IDLE, command accepted on cycle N: latch we/addr/data/sel; cyc=stb=1 from cycle N+1; enter REQ.
REQ-015 REQ: stb held with stable addr/data/we/sel while wb_stall_i=1; on wb_stall_i=0, deassert stb next cycle, keep cyc, enter WAIT.
REQ-016 wb_ack_i or wb_err_i SHALL be honoured in REQ or WAIT, regardless of wb_stall_i. The same cycle as stall=0 in REQ counts. cyc and stb drop next cycle. Enter RSP.
REQ-017 On ack: rsp_data_o=wb_data_i for a read, 0 for a write; rsp_err_o=0.
REQ-018 On err, or ack and err together: err wins; rsp_err_o=1, rsp_data_o=0.
REQ-019 Timeout counter: cleared on command accept, incremented each cycle in REQ/WAIT.
REQ-020 Timeout abort: counter reaches TIMEOUT with no ack/err. Drop cyc/stb next cycle. Set rsp_err_o=1, rsp_timeout_o=1, rsp_data_o=0. Enter RSP.
REQ-021 Ack/err on the same cycle the counter reaches TIMEOUT: ack/err SHALL win; no timeout reported.
REQ-022 RSP: rsp_valid_o=1; response fields stable until rsp_ready_i. On handshake, return to IDLE.
REQ-023 Back-pressure: the next command is accepted no earlier than the cycle after the response handshake.
REQ-024 Ack/err arriving in IDLE or RSP SHALL be ignored.
REQ-025 Minimum latency, command accept (N) to rsp_valid_o: N+2 for a slave acking in the stb cycle; N+3 for a registered-ack slave.
REQ-026 At most one transaction in flight.

Reset
REQ-027 rst_i SHALL force IDLE with all outputs low or zero: wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o, rsp_*, and cmd_ready_o.
REQ-028 cmd_ready_o SHALL be 1 on the first cycle after reset release.
REQ-029 Reset mid-transaction SHALL drop cyc/stb the next cycle and discard any pending response.

Structure
REQ-030 Package wb_cmd_master_pkg SHALL hold the FSM state enum and the response-flag struct.
REQ-031 No sub-module; timeout counter is inline, width $clog2(TIMEOUT+1).

Verification
REQ-032 Read, zero-stall slave, registered ack next cycle, wb_data_i=32'hDEADBEEF: rsp_valid at N+3, rsp_data=32'hDEADBEEF, err=0, timeout=0.
REQ-033 Write addr 8'h04, data 32'h12345678, sel 4'hF, stall=1 for 3 cycles: stb high 4 cycles with stable outputs, then one ack; rsp_err=0, rsp_data=0.
REQ-034 Slave asserts ack and err together: rsp_err=1, rsp_data=0, cyc drops next cycle.
REQ-035 TIMEOUT=4, slave silent: cyc drops after 4 cycles; rsp_err=1, rsp_timeout=1.
REQ-036 rsp_ready held low 5 cycles: response stable, cmd_ready=0. After handshake, back-to-back command accepted the next cycle.
REQ-037 rst_i pulsed during WAIT: cyc=0 next cycle, rsp_valid=0, cmd_ready=1 after release; a late ack is ignored.
